// File: rtl/riscv_pkg.sv
// Shared core-wide definitions: datapath width plus the trace buffer's mode/state types.
// Also holds a small saturating-counter helper used by the loss counter.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        DROP_NEW  = 1'b0,
        OVERWRITE = 1'b1
    } trace_mode_e;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } trace_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
// Contents are only meaningful where the FIFO pointers say an entry is live.
module trace_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int WIDTH = 96
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; occupancy tracking makes stale entries invisible,
    // and leaving it out keeps the array mappable onto plain RAM/flops without a reset tree.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/commit_trace_buffer.sv
// Show-ahead trace FIFO of committed instructions with drop/overwrite overflow
// policy, loss accounting, a retired-instruction counter and a PC breakpoint halt.
module commit_trace_buffer #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int DEPTH = 16,
    parameter int SEQW  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         update_i,
    input  logic [XLEN-1:0]              pc_i,
    input  logic [XLEN-1:0]              data_i,
    input  logic                         mode_i,
    input  logic                         bp_en_i,
    input  logic [XLEN-1:0]              bp_addr_i,
    input  logic                         resume_i,
    input  logic                         clear_i,
    input  logic                         rd_ready_i,
    output logic                         rd_valid_o,
    output logic [XLEN-1:0]              rd_pc_o,
    output logic [XLEN-1:0]              rd_data_o,
    output logic [SEQW-1:0]              rd_seq_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         overflow_o,
    output logic [15:0]                  drop_cnt_o,
    output logic [63:0]                  retired_o,
    output logic                         halt_o
);

    import riscv_pkg::*;

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int ENTW = 2 * XLEN + SEQW;

    trace_state_e      state_q,    state_d;
    logic [PTRW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [PTRW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [CNTW-1:0]   count_q,    count_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [63:0]       retired_q,  retired_d;

    trace_mode_e       mode;
    logic              pop;
    logic              capture;
    logic              full;
    logic              push;
    logic              lost;
    logic              overwrite;
    logic              mem_we;
    logic [ENTW-1:0]   wr_entry;
    logic [ENTW-1:0]   rd_entry;

    assign mode = trace_mode_e'(mode_i);

    // Classify this cycle's commit: a pop frees a slot in the same cycle, so a
    // full buffer only loses something when nothing is leaving.
    always_comb begin
        pop       = (count_q != '0) && rd_ready_i;
        capture   = (state_q == RUN) && update_i && !clear_i;
        full      = (count_q == CNTW'(DEPTH));
        push      = capture && (!full || pop);
        lost      = capture && full && !pop;
        overwrite = lost && (mode == OVERWRITE);
        mem_we    = push || overwrite;
        wr_entry  = {pc_i, data_i, retired_q[SEQW-1:0]};
    end

    // NOTE: every signal assigned below takes its hold value first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        retired_d  = retired_q;

        if (clear_i) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            // Overwrite retires the head and reuses its slot, so both pointers advance.
            if (pop || overwrite) begin
                rd_ptr_d = rd_ptr_q + PTRW'(1);
            end
            if (mem_we) begin
                wr_ptr_d = wr_ptr_q + PTRW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNTW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNTW'(1);
            end

            if (lost) begin
                overflow_d = 1'b1;
                drop_cnt_d = sat_inc16(drop_cnt_q);
            end

            if (capture) begin
                retired_d = retired_q + 64'd1;
                if (bp_en_i && (pc_i == bp_addr_i)) begin
                    state_d = HALTED;
                end
            end else if ((state_q == HALTED) && resume_i) begin
                state_d = RUN;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            retired_q  <= retired_d;
        end
    end

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (PTRW),
        .WIDTH (ENTW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign rd_valid_o = (count_q != '0);
    assign rd_pc_o    = rd_entry[ENTW-1 -: XLEN];
    assign rd_data_o  = rd_entry[SEQW +: XLEN];
    assign rd_seq_o   = rd_entry[SEQW-1:0];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;
    assign retired_o  = retired_q;
    assign halt_o     = (state_q == HALTED);

endmodule
